// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: shared constants and FSM encoding for the instruction fetch unit
package ysyx_220053_pkg;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} ifu_state_t;
endpackage

// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: single-outstanding instruction fetch with decode redirect and drain of stale responses
module ysyx_220053_ifu
   import ysyx_220053_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [63:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr
);
   ifu_state_t state, state_n;
   logic [63:0] pc, pc_n, target;
   logic load;
   always_comb begin
      state_n = state;
      target = redirect_pc & ~64'h3;
      unique case (state)
         S_REQ:   state_n = imem_gnt ? (redirect_valid ? S_DRAIN : S_WAIT) : S_REQ;
         S_WAIT:  state_n = imem_rvalid ? (redirect_valid ? S_REQ : S_HOLD)
                                        : (redirect_valid ? S_DRAIN : S_WAIT);
         S_HOLD:  state_n = (redirect_valid || out_ready) ? S_REQ : S_HOLD;
         S_DRAIN: state_n = imem_rvalid ? S_REQ : S_DRAIN;
      endcase
      // a redirect wins over every other event, including a consuming handshake
      pc_n = redirect_valid ? target : (state == S_HOLD && out_ready) ? pc + 64'd4 : pc;
      load = state == S_WAIT && imem_rvalid && !redirect_valid;
      imem_req = state == S_REQ && !rst;
      imem_addr = pc & ~64'h7;
      out_valid = state == S_HOLD;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
         pc <= RESET_PC;
         out_pc <= '0;
         out_instr <= NOP;
      end else begin
         state <= state_n;
         pc <= pc_n;
         if (load) begin
            out_pc <= pc;
            out_instr <= pc[2] ? imem_rdata[63:32] : imem_rdata[31:0];
         end
      end
   end
endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// tb_ysyx_220053_ifu: scenario tasks drive a hand-timed memory; a monitor pops expected fetches on each handshake
module tb_ysyx_220053_ifu;
   typedef struct packed {logic [63:0] pc; logic [31:0] instr;} exp_t;
   logic clk = 0, rst = 1;
   logic imem_req, imem_gnt = 0, imem_rvalid = 0;
   logic [63:0] imem_addr, imem_rdata = 64'hdead_beef_dead_beef;
   logic redirect_valid = 0, out_valid, out_ready = 0;
   logic [63:0] redirect_pc = '0, out_pc, exp_pc;
   logic [31:0] out_instr;
   exp_t q[$];
   int n_checks = 0, n_fail = 0, n_pops = 0;

   ysyx_220053_ifu dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !redirect_valid) begin
         exp_t e;
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL consume: unexpected instr pc=%h instr=%h, none expected", out_pc, out_instr);
         end else begin
            e = q.pop_front();
            n_pops++;
            if (out_pc !== e.pc || out_instr !== e.instr) begin
               n_fail++;
               $display("FAIL consume: got pc=%h instr=%h, expected pc=%h instr=%h", out_pc, out_instr, e.pc, e.instr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_req(input string name, input logic [63:0] pc);
      n_checks++;
      if (imem_req !== 1'b1 || out_valid !== 1'b0 || imem_addr !== {pc[63:3], 3'b000}) begin
         n_fail++;
         $display("FAIL %s: req=%b valid=%b addr=%h, expected req=1 valid=0 addr=%h", name, imem_req, out_valid, imem_addr, {pc[63:3], 3'b000});
      end
   endtask

   task automatic expect_idle(input string name);
      n_checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: req=%b valid=%b, expected both 0", name, imem_req, out_valid);
      end
   endtask

   // full fetch from REQ; optionally ends with a redirect that kills the held instruction
   task automatic do_fetch(input logic [63:0] rd, input int gw, input int rw, input int hold,
                           input logic redir, input logic [63:0] tgt);
      logic [31:0] ins;
      repeat (gw) begin
         expect_req("req_wait", exp_pc);
         tick();
      end
      expect_req("req", exp_pc);
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      expect_idle("wait");
      repeat (rw) begin
         tick();
         expect_idle("wait_rv");
      end
      imem_rvalid = 1;
      imem_rdata = rd;
      ins = exp_pc[2] ? rd[63:32] : rd[31:0];
      q.push_back({exp_pc, ins});
      tick();
      imem_rvalid = 0;
      imem_rdata = 64'hdead_beef_dead_beef;
      for (int i = 0; i <= hold; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || imem_req !== 1'b0 || out_pc !== exp_pc || out_instr !== ins) begin
            n_fail++;
            $display("FAIL hold: valid=%b req=%b pc=%h instr=%h, expected valid=1 req=0 pc=%h instr=%h", out_valid, imem_req, out_pc, out_instr, exp_pc, ins);
         end
         if (i < hold) tick();
      end
      out_ready = 1;
      if (redir) begin
         redirect_valid = 1;
         redirect_pc = tgt;
      end
      tick();
      out_ready = 0;
      redirect_valid = 0;
      if (redir) begin
         void'(q.pop_back());
         exp_pc = {tgt[63:2], 2'b00};
      end else exp_pc = exp_pc + 64'd4;
      expect_req("after_hold", exp_pc);
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL reset: req=%b valid=%b pc=%h instr=%h, expected 0 0 0 00000013", imem_req, out_valid, out_pc, out_instr);
      end
      rst = 0;
      #1;
      exp_pc = 64'h8000_0000;
      expect_req("reset_first_req", exp_pc);
   endtask

   task automatic test_basic_fetch();
      do_fetch(64'h1234_5678_9abc_def0, 0, 0, 0, 0, '0);
      do_fetch(64'h0010_0093_0000_0013, 0, 0, 5, 0, '0);
      n_checks++;
      if (n_pops != 2) begin
         n_fail++;
         $display("FAIL basic_pops: got %0d consumed, expected 2", n_pops);
      end
   endtask

   task automatic test_back_to_back();
      do_fetch(64'h1111_2222_3333_4444, 0, 0, 0, 0, '0);
      do_fetch(64'h5555_6666_7777_8888, 2, 1, 0, 0, '0);
      do_fetch(64'h9999_aaaa_bbbb_cccc, 1, 3, 2, 0, '0);
   endtask

   task automatic test_redirect_wait_rvalid();
      expect_req("rwr_req", exp_pc);
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      imem_rvalid = 1;
      imem_rdata = 64'h0bad_0bad_0bad_0bad;
      redirect_valid = 1;
      redirect_pc = 64'h8000_0100;
      tick();
      imem_rvalid = 0;
      redirect_valid = 0;
      exp_pc = 64'h8000_0100;
      expect_req("rwr_next", exp_pc);
      do_fetch(64'hcafe_0001_cafe_0000, 0, 0, 0, 0, '0);
   endtask

   task automatic test_drain();
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      redirect_valid = 1;
      redirect_pc = 64'h8000_0200;
      tick();
      redirect_valid = 0;
      exp_pc = 64'h8000_0200;
      expect_idle("drain0");
      tick();
      expect_idle("drain1");
      tick();
      expect_idle("drain2");
      imem_rvalid = 1;
      tick();
      imem_rvalid = 0;
      expect_req("drain_exit", exp_pc);
      do_fetch(64'hfeed_0203_feed_0200, 0, 1, 0, 0, '0);
   endtask

   task automatic test_redirect_hold();
      do_fetch(64'h0abc_0abc_0abc_0abc, 0, 0, 1, 1, 64'h8000_0304);
      n_checks++;
      if (out_pc === 64'h8000_0208) begin
         n_fail++;
         $display("FAIL hold_redirect_pc: out_pc=%h, expected not old pc+4", out_pc);
      end
      do_fetch(64'h0304_0304_0300_0300, 0, 0, 0, 0, '0);
   endtask

   task automatic test_redirect_req();
      redirect_valid = 1;
      redirect_pc = 64'h8000_0403;
      tick();
      redirect_valid = 0;
      exp_pc = 64'h8000_0400;
      expect_req("req_redirect", exp_pc);
      do_fetch(64'h0404_0404_0400_0400, 0, 0, 0, 0, '0);
      imem_gnt = 1;
      redirect_valid = 1;
      redirect_pc = 64'h8000_0500;
      tick();
      imem_gnt = 0;
      redirect_pc = 64'h8000_0506;
      expect_idle("gnt_redirect_drain");
      tick();
      redirect_valid = 0;
      exp_pc = 64'h8000_0504;
      expect_idle("drain_redirect");
      imem_rvalid = 1;
      tick();
      imem_rvalid = 0;
      expect_req("drain_redirect_exit", exp_pc);
      do_fetch(64'h0504_0504_0500_0500, 0, 0, 0, 0, '0);
      redirect_valid = 1;
      redirect_pc = 64'hffff_ffff_ffff_fffc;
      tick();
      redirect_valid = 0;
      exp_pc = 64'hffff_ffff_ffff_fffc;
      do_fetch(64'h7777_0001_6666_0000, 0, 0, 0, 0, '0);
      n_checks++;
      if (imem_addr !== 64'h0) begin
         n_fail++;
         $display("FAIL wrap: addr=%h, expected 0", imem_addr);
      end
   endtask

   task automatic test_reset_mid_wait();
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      rst = 1;
      tick();
      rst = 0;
      #1;
      exp_pc = 64'h8000_0000;
      n_checks++;
      if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL mid_wait_reset: valid=%b pc=%h instr=%h, expected 0 0 00000013", out_valid, out_pc, out_instr);
      end
      expect_req("mid_wait_reset_req", exp_pc);
      do_fetch(64'h0000_0093_0000_0113, 0, 0, 0, 0, '0);
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_back_to_back();
      test_redirect_wait_rvalid();
      test_drain();
      test_redirect_hold();
      test_redirect_req();
      test_reset_mid_wait();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ysyx_220053_ifu.md
YSYX_220053_IFU -- requirements
Module: ysyx_220053_IFU

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  64  doubleword-aligned fetch address, {pc[63:3],3'b000}.
REQ-006 imem_gnt  input  1  memory accepts request in the cycle it is high with imem_req.
REQ-007 imem_rvalid  input  1  read data valid, at earliest one cycle after the accepting gnt.
REQ-008 imem_rdata  input  64  read doubleword.
REQ-009 redirect_valid  input  1  next-PC override from decode (branch/jump/ecall/mret).
REQ-010 redirect_pc  input  64  override target (decode dnpc).
REQ-011 out_valid  output  1  instruction register holds a valid instruction for decode.
REQ-012 out_ready  input  1  decode consumes the instruction when out_valid && out_ready.
REQ-013 out_pc  output  64  PC of the presented instruction.
REQ-014 out_instr  output  32  presented instruction word.

Function
REQ-015 The block SHALL be a 4-state FSM: REQ, WAIT, HOLD, DRAIN; one fetch outstanding at most.
REQ-016 REQ: imem_req=1; on imem_gnt, go to WAIT; otherwise stay in REQ.
REQ-017 WAIT: on imem_rvalid, latch out_instr = pc[2] ? rdata[63:32] : rdata[31:0], latch out_pc = pc, go to HOLD.
REQ-018 HOLD: out_valid=1; on out_ready, pc <= pc+4 (64-bit wrap), go to REQ.
REQ-019 out_valid SHALL be 1 only in HOLD; out_pc/out_instr SHALL remain stable while out_valid && !out_ready.
REQ-020 Fetch latency from entering REQ to out_valid SHALL be gnt-wait + rvalid-wait + 1 cycle; the minimum is 2 cycles after REQ entry. Peak throughput is one instruction per 3 cycles.
REQ-021 Redirect target SHALL be {redirect_pc[63:2],2'b00}; redirect SHALL take priority over every other event in the same cycle.
REQ-022 Redirect in REQ without gnt: pc <= target, stay in REQ; imem_addr may change only while gnt is low.
REQ-023 Redirect in REQ with gnt in the same cycle: pc <= target, go to DRAIN.
REQ-024 Redirect in WAIT without rvalid: pc <= target, go to DRAIN. Redirect in WAIT with rvalid: discard the data, pc <= target, go to REQ.
REQ-025 Redirect in HOLD, including with out_ready high: drop out_valid next cycle, pc <= target, go to REQ; the held instruction is not counted as consumed.
REQ-026 DRAIN: imem_req=0, out_valid=0; on rvalid, discard the data and go to REQ. A further redirect in DRAIN only updates pc.
REQ-027 imem_req SHALL be 0 in WAIT, HOLD and DRAIN.

Reset
REQ-028 On a clk edge with rst=1: state=REQ, pc=RESET_PC, out_valid=0, out_pc=0, out_instr=32'h0000_0013 (nop), imem_req=0 during the reset cycle.
REQ-029 Reset SHALL override all inputs. A response for a request issued before reset SHALL NOT be presented; the memory is reset together with this block.

Structure
REQ-030 RESET_PC default, the FSM state encoding (2 bits) and the NOP constant SHALL live in package ysyx_220053_pkg.
REQ-031 No sub-module is required; the word select SHALL be inline logic.

Verification
REQ-032 Reset, gnt and rvalid one cycle after req -> imem_addr=0x8000_0000; out_valid rises 2 cycles after REQ entry with out_pc=0x8000_0000, out_instr=rdata[31:0].
REQ-033 pc=0x8000_0004, rdata=0x00100093_00000013 -> out_instr=0x00100093. Hold out_ready=0 for 5 cycles -> outputs stable and imem_req=0.
REQ-034 Redirect to 0x8000_0100 in the same cycle as rvalid in WAIT -> data discarded, next imem_addr=0x8000_0100, no out_valid for the old pc.
REQ-035 Redirect to 0x8000_0200 in WAIT, rvalid 3 cycles later -> DRAIN, no out_valid; next request at 0x8000_0200 after rvalid.
REQ-036 Redirect to 0x8000_0304 in HOLD with out_ready=1 -> next presented out_pc=0x8000_0304, not old pc+4.
REQ-037 rst asserted mid-WAIT -> next cycle out_valid=0 and pc=0x8000_0000; next request at 0x8000_0000.
